cbm2_rom_loader: RTL
====================

Name: cbm2_rom_loader

Overview:
- Writer side of the system ROM blocks: takes the MiSTer ioctl download byte stream and writes the BASIC lo, BASIC hi, kernal and character ROM images through the ROMs' write port (port A of rom_mem).
- Sits between hps_io and the bus logic ROM instances.
- Drives per-ROM address, data and one-hot select, plus a CPU hold.
- Pads short images with a fill byte and flags malformed downloads.

Parameters:
ROM_INDEX, 8'd0, ioctl_index value that selects the system ROM set; other indices are ignored.
FILL_BYTE, 8'hFF, value written to image bytes not supplied by a short download.

Ports:
clk_sys  in  1  system clock
reset_n  in  1  synchronous reset, active low
ioctl_download  in  1  download active
ioctl_index  in  8  image index
ioctl_wr  in  1  byte strobe (1 cycle)
ioctl_addr  in  16  byte offset in image
ioctl_dout  in  8  byte data
ioctl_wait  out  1  back-pressure to hps_io
rom_addr  out  13  offset within target ROM
rom_data  out  8  write data
rom_wr  out  1  write strobe
rom_sel  out  4  one-hot target: [0]=rom8 $8000, [1]=romA $A000, [2]=romE kernal, [3]=romC char
cpu_hold  out  1  keep CPU/bus in reset while ROMs are being rewritten
load_done  out  1  one-cycle pulse when a load completes
load_err  out  1  sticky error from last load

Behaviour:
Reset and interface:
- One clock domain. reset_n is synchronous and active low.
- On reset: all outputs 0, state IDLE.
- ROM contents are never rolled back; a reset mid-load leaves partial contents.

Image layout (fixed, 0x7000 bytes):
- 0x0000-0x1FFF -> rom8
- 0x2000-0x3FFF -> romA
- 0x4000-0x5FFF -> romE
- 0x6000-0x6FFF -> romC, using rom_addr[11:0] with rom_addr[12]=0
- Decode: rom_sel from ioctl_addr[14:12]; rom_addr = ioctl_addr[12:0].

States:
- IDLE: ioctl_download=1 and ioctl_index==ROM_INDEX -> ARMED. On entry: cpu_hold=1, load_err=0, hi_addr cleared, any_byte=0. A download with another index is ignored entirely and cpu_hold stays 0.
- ARMED: on ioctl_wr (only honoured while ioctl_download=1):
  - If ioctl_addr < 0x7000: register addr/data/sel, go to WRITE. Set any_byte; hi_addr = max(hi_addr, ioctl_addr).
  - If ioctl_addr >= 0x7000: drop the byte, set load_err, stay in ARMED.
  - If ioctl_download=0 with no wr: go to FILL when any_byte and hi_addr < 0x6FFF; otherwise go to FINISH. If no byte was accepted, also set load_err.
- WRITE: exactly one cycle.
  - rom_wr=1 with registered addr/data/sel. ioctl_wait=1.
  - Next state ARMED; ioctl_wait drops in that cycle.
  - Latency: wr accepted in cycle N, rom_wr in N+1, ioctl_wait high in N+1 only.
  - An ioctl_wr arriving during WRITE is a protocol violation: byte dropped, load_err set.
- FILL:
  - fill_ptr starts at hi_addr+1 and increments by 1 per cycle up to and including 0x6FFF.
  - Each cycle: rom_wr=1, rom_data=FILL_BYTE, rom_sel/rom_addr decoded from fill_ptr as in the layout.
  - After writing 0x6FFF -> FINISH.
  - A new download starting during FILL is ignored until IDLE.
- FINISH: one cycle; load_done=1, cpu_hold=0, then -> IDLE.

Outputs and flags:
- rom_wr is never 1 outside WRITE/FILL.
- rom_sel is exactly one-hot whenever rom_wr=1, and 0 otherwise.
- Out-of-order addresses are written where addressed. Fill covers only addresses above the highest accepted address; holes below it are not filled.
- load_err stays set until the next matching download starts.
- Wrap: hi_addr and fill_ptr are 16 bit; fill never exceeds 0x6FFF.

Test Plan:
- Full 0x7000-byte sequential download (byte = addr[7:0]^addr[15:8]) -> 28672 rom_wr pulses with correct sel/addr; no FILL; load_done 1 pulse; load_err=0; cpu_hold high from download rise to FINISH.
- Download of only 0x100 bytes -> 0x6F00 FILL writes of 8'hFF covering rom8 0x100-0x1FFF, romA, romE, and romC 0x000-0xFFF; last write romC addr 0xFFF; then load_done.
- Byte at ioctl_addr 0x7000 within an otherwise full image -> that byte dropped, no rom_wr for it, load_err=1 after FINISH; cleared at the next download start.
- ioctl_wr asserted on two consecutive cycles -> first byte written at N+1 with ioctl_wait=1; second byte dropped; load_err=1.
- Download with ioctl_index=ROM_INDEX+1 -> no rom_wr, cpu_hold=0, no load_done.
- reset_n low during FILL at fill_ptr 0x3000 -> next cycle all outputs 0 and state IDLE. A following 0-byte download -> load_err=1, load_done pulse, no writes.

Source files
------------

// File: rtl/cbm2_rom_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cbm2_rom_loader: writes the ioctl ROM download into the system ROM blocks |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cbm2_rom_loader #(
  parameter logic [7:0] ROM_INDEX = 8'd0,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [12:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        rom_wr,
  output logic [3:0]  rom_sel,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARMED  = 3'd1;
  localparam logic [2:0] WRITE  = 3'd2;
  localparam logic [2:0] FILL   = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam logic [15:0] IMAGE_LAST = 16'h6FFF;

  logic [2:0]  state;
  logic [15:0] hi_addr;
  logic [15:0] fill_ptr;
  logic        any_byte;
  logic        hold;
  logic        err;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  wr_sel;

  // 4 KB granule of the image -> target ROM; the char ROM occupies only 0x6xxx
  function automatic logic [3:0] decode_sel(input logic [2:0] blk);
    case (blk)
      3'b000, 3'b001: decode_sel = 4'b0001;
      3'b010, 3'b011: decode_sel = 4'b0010;
      3'b100, 3'b101: decode_sel = 4'b0100;
      3'b110:         decode_sel = 4'b1000;
      default:        decode_sel = 4'b0000;
    endcase
  endfunction

  always_comb begin
    rom_wr     = 1'b0;
    rom_sel    = 4'b0000;
    rom_addr   = 13'd0;
    rom_data   = 8'd0;
    ioctl_wait = 1'b0;
    load_done  = 1'b0;
    case (state)
      WRITE: begin
        rom_wr     = 1'b1;
        rom_sel    = wr_sel;
        rom_addr   = wr_addr;
        rom_data   = wr_data;
        ioctl_wait = 1'b1;
      end
      FILL: begin
        rom_wr   = 1'b1;
        rom_sel  = decode_sel(fill_ptr[14:12]);
        rom_addr = fill_ptr[12:0];
        rom_data = FILL_BYTE;
      end
      FINISH:  load_done = 1'b1;
      default: ;
    endcase
  end

  assign cpu_hold = hold;
  assign load_err = err;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state    <= IDLE;
      hi_addr  <= 16'd0;
      fill_ptr <= 16'd0;
      any_byte <= 1'b0;
      hold     <= 1'b0;
      err      <= 1'b0;
      wr_addr  <= 13'd0;
      wr_data  <= 8'd0;
      wr_sel   <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (ioctl_download && ioctl_index == ROM_INDEX) begin
            state    <= ARMED;
            hold     <= 1'b1;
            err      <= 1'b0;
            hi_addr  <= 16'd0;
            any_byte <= 1'b0;
          end
        end
        ARMED: begin
          // end of download takes priority: a strobe without download is ignored
          if (!ioctl_download) begin
            if (any_byte && hi_addr < IMAGE_LAST) begin
              state    <= FILL;
              fill_ptr <= hi_addr + 16'd1;
            end else begin
              state <= FINISH;
              hold  <= 1'b0;
              if (!any_byte) err <= 1'b1;
            end
          end else if (ioctl_wr) begin
            if (ioctl_addr <= IMAGE_LAST) begin
              state    <= WRITE;
              wr_addr  <= ioctl_addr[12:0];
              wr_data  <= ioctl_dout;
              wr_sel   <= decode_sel(ioctl_addr[14:12]);
              any_byte <= 1'b1;
              if (ioctl_addr > hi_addr) hi_addr <= ioctl_addr;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (ioctl_wr) err <= 1'b1;
          state <= ARMED;
        end
        FILL: begin
          fill_ptr <= fill_ptr + 16'd1;
          if (fill_ptr == IMAGE_LAST) begin
            state <= FINISH;
            hold  <= 1'b0;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
